// File: rtl/lupdate_if.sv
// Packet stream seen by lupdate: the upstream words coming in and the delayed words going out.
// A word moves in every cycle its *_data_wr strobe is high; there is no back-pressure, so the receiver takes every strobed word, and *_data_valid is meaningful only together with *_data_valid_wr (tail word).
interface lupdate_if;
    logic         in_lu_data_wr;
    logic [133:0] in_lu_data;
    logic         in_lu_data_valid;
    logic         in_lu_data_valid_wr;
    logic         out_lu_data_wr;
    logic [133:0] out_lu_data;
    logic         out_lu_data_valid;
    logic         out_lu_data_valid_wr;

    modport master (
        output in_lu_data_wr, in_lu_data, in_lu_data_valid, in_lu_data_valid_wr,
        input  out_lu_data_wr, out_lu_data, out_lu_data_valid, out_lu_data_valid_wr
    );

    modport slave (
        input  in_lu_data_wr, in_lu_data, in_lu_data_valid, in_lu_data_valid_wr,
        output out_lu_data_wr, out_lu_data, out_lu_data_valid, out_lu_data_valid_wr
    );
endinterface

// File: rtl/lupdate.sv
// Beacon-update consumer: swallows beacon updates addressed to this switch, applies their
// config words, and forwards every other packet through a fixed 3-cycle pipeline.
module lupdate #(
    parameter logic [3:0]  UPD_TYPE  = 4'hd,
    parameter logic [15:0] PTP_ETYPE = 16'h88f7,
    parameter logic [31:0] DEF_SLOT  = 32'd1000,
    parameter logic [31:0] DEF_TB    = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    lupdate_if.slave    lu,
    input  logic [47:0] in_local_mac_id,
    output logic        beacon_update_master,
    output logic        direction,
    output logic [47:0] direct_mac_addr,
    output logic [31:0] token_bucket_para,
    output logic [31:0] time_slot_period,
    output logic [15:0] upd_cnt,
    output logic [15:0] upd_err_cnt,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DROP, S_PASS} state_t;

    typedef struct packed {
        logic [133:0] data;
        logic         wr;
        logic         valid;
        logic         valid_wr;
        logic         drop;
    } stage_t;

    state_t       r_state, w_state_nxt;
    stage_t       r_st [3];
    logic [3:0]   r_widx;
    logic [47:0]  r_sh_mac;
    logic         r_sh_dir;
    logic [31:0]  r_sh_tb, r_sh_slot;
    logic         r_master, r_dir;
    logic [47:0]  r_mac;
    logic [31:0]  r_tb, r_slot;
    logic [15:0]  r_cnt, r_err;

    logic         w_wr, w_head, w_tail, w_hit, w_match, w_in_drop, w_commit, w_trunc;
    logic [3:0]   w_idx;
    logic [127:0] w_pl;
    logic [47:0]  w_src_mac;
    logic         w_src_dir;
    logic [31:0]  w_src_tb, w_src_slot;

    assign w_pl   = lu.in_lu_data[127:0];
    assign w_wr   = lu.in_lu_data_wr;
    assign w_head = w_wr && (lu.in_lu_data[133:132] == 2'b01);
    assign w_tail = w_wr && (lu.in_lu_data[133:132] == 2'b10);
    assign w_idx  = w_head ? 4'd0 : ((r_widx == 4'hf) ? 4'hf : r_widx + 4'd1);

    assign w_hit   = (w_pl[127:80] == in_local_mac_id) && (w_pl[31:16] == PTP_ETYPE)
                     && (w_pl[11:8] == UPD_TYPE);
    assign w_match = w_wr && !w_head && (r_state == S_HDR) && (w_idx == 4'd2) && w_hit;
    // Tag carried with each word so an aborted packet's words keep their own drop decision.
    assign w_in_drop = w_wr && !w_head && ((r_state == S_DROP) || w_match);
    assign w_commit  = w_tail && (r_state == S_DROP) && (w_idx >= 4'd6);
    assign w_trunc   = w_tail && ((r_state == S_DROP) || w_match) && (w_idx < 4'd6);

    // A tail that is itself word 6 commits straight from the input.
    assign w_src_mac  = (w_idx == 4'd6) ? w_pl[127:80] : r_sh_mac;
    assign w_src_dir  = (w_idx == 4'd6) ? w_pl[79]     : r_sh_dir;
    assign w_src_tb   = (w_idx == 4'd6) ? w_pl[63:32]  : r_sh_tb;
    assign w_src_slot = (w_idx == 4'd6) ? w_pl[31:0]   : r_sh_slot;

    always_comb begin
        w_state_nxt = r_state;
        if (w_head) begin
            w_state_nxt = S_HDR;
        end else if (w_wr) begin
            case (r_state)
                S_HDR: begin
                    if (w_tail)            w_state_nxt = S_IDLE;
                    else if (w_idx == 4'd2) w_state_nxt = w_match ? S_DROP : S_PASS;
                end
                S_DROP, S_PASS: if (w_tail) w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_widx  <= 4'd0;
            for (int i = 0; i < 3; i++) r_st[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr) r_widx <= w_idx;
            r_st[0] <= '{data: lu.in_lu_data, wr: w_wr, valid: lu.in_lu_data_valid,
                         valid_wr: lu.in_lu_data_valid_wr, drop: w_in_drop};
            r_st[1] <= r_st[0];
            r_st[2] <= r_st[1];
            if (w_match) begin
                r_st[1].drop <= 1'b1;
                r_st[2].drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_mac  <= '0;
            r_sh_dir  <= 1'b0;
            r_sh_tb   <= '0;
            r_sh_slot <= '0;
            r_master  <= 1'b0;
            r_dir     <= 1'b0;
            r_mac     <= '0;
            r_tb      <= DEF_TB;
            r_slot    <= DEF_SLOT;
            r_cnt     <= '0;
            r_err     <= '0;
        end else begin
            if ((r_state == S_DROP) && w_wr && !w_head && (w_idx == 4'd6)) begin
                r_sh_mac  <= w_pl[127:80];
                r_sh_dir  <= w_pl[79];
                r_sh_tb   <= w_pl[63:32];
                r_sh_slot <= w_pl[31:0];
            end
            if (w_commit) begin
                r_mac    <= w_src_mac;
                r_dir    <= w_src_dir;
                r_tb     <= w_src_tb;
                r_slot   <= w_src_slot;
                r_master <= ~r_master;
                r_cnt    <= r_cnt + 16'd1;
            end
            if (w_trunc && (r_err != 16'hffff)) r_err <= r_err + 16'd1;
        end
    end

    assign lu.out_lu_data_wr       = r_st[2].wr       & ~r_st[2].drop;
    assign lu.out_lu_data          = r_st[2].drop ? '0 : r_st[2].data;
    assign lu.out_lu_data_valid    = r_st[2].valid    & ~r_st[2].drop;
    assign lu.out_lu_data_valid_wr = r_st[2].valid_wr & ~r_st[2].drop;

    assign beacon_update_master = r_master;
    assign direction            = r_dir;
    assign direct_mac_addr      = r_mac;
    assign token_bucket_para    = r_tb;
    assign time_slot_period     = r_slot;
    assign upd_cnt              = r_cnt;
    assign upd_err_cnt          = r_err;
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_lupdate.sv
// Bench for lupdate: directed scenarios plus random packets, checked by a packet-level model
// and an expected-word queue drained by an output monitor.
module tb_lupdate;

    localparam logic [47:0] MAC = 48'h02_11_22_33_44_55;

    typedef struct packed {
        logic [133:0] data;
        logic         valid;
        logic         vwr;
        logic [31:0]  cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] local_mac = MAC;
    logic        master, dir;
    logic [47:0] dmac;
    logic [31:0] tb_para, slot;
    logic [15:0] cnt, err_cnt;
    logic [1:0]  dbg_state;

    lupdate_if lu();

    lupdate dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .lu                   (lu),
        .in_local_mac_id      (local_mac),
        .beacon_update_master (master),
        .direction            (dir),
        .direct_mac_addr      (dmac),
        .token_bucket_para    (tb_para),
        .time_slot_period     (slot),
        .upd_cnt              (cnt),
        .upd_err_cnt          (err_cnt),
        .o_dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Reference model of the applied configuration
    logic        m_master, m_dir;
    logic [47:0] m_mac;
    logic [31:0] m_tb, m_slot;
    logic [15:0] m_cnt, m_err;

    logic [127:0] pw [20];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_master = 1'b0; m_dir = 1'b0; m_mac = '0;
        m_tb = 32'd0; m_slot = 32'd1000; m_cnt = '0; m_err = '0;
    endtask

    task automatic check_cfg();
        chk("master", master, m_master);
        chk("direction", dir, m_dir);
        chk("direct_mac", dmac, m_mac);
        chk("token_bucket", tb_para, m_tb);
        chk("slot", slot, m_slot);
        chk("upd_cnt", cnt, m_cnt);
        chk("upd_err_cnt", err_cnt, m_err);
    endtask

    task automatic drive_idle();
        lu.in_lu_data_wr = 1'b0;
        lu.in_lu_data = '0;
        lu.in_lu_data_valid = 1'b0;
        lu.in_lu_data_valid_wr = 1'b0;
    endtask

    // kind 0: matching update; 1..3: one of the three match fields wrong
    task automatic make_pkt(input int kind);
        for (int i = 0; i < 20; i++) pw[i] = {$urandom, $urandom, $urandom, $urandom};
        pw[2][127:80] = MAC;
        pw[2][31:16]  = 16'h88f7;
        pw[2][11:8]   = 4'hd;
        case (kind)
            1: pw[2][127:80] = MAC ^ 48'h1;
            2: pw[2][31:16]  = 16'h0800;
            3: pw[2][11:8]   = 4'h3;
            default: ;
        endcase
    endtask

    task automatic send_pkt(input int n, input bit has_tail, input int gap);
        bit           hit, drop, tail;
        logic [1:0]   tag;
        logic [133:0] w;
        logic         v;
        hit  = (pw[2][127:80] == MAC) && (pw[2][31:16] == 16'h88f7) && (pw[2][11:8] == 4'hd);
        drop = (n >= 3) && hit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_cfg();
            tail = has_tail && (i == n - 1);
            tag  = (i == 0) ? 2'b01 : (tail ? 2'b10 : 2'b11);
            w    = {tag, 4'($urandom), pw[i]};
            v    = tail ? 1'($urandom_range(0, 1)) : 1'b0;
            lu.in_lu_data_wr = 1'b1;
            lu.in_lu_data = w;
            lu.in_lu_data_valid = v;
            lu.in_lu_data_valid_wr = tail;
            if (!drop) exp_q.push_back('{data: w, valid: v, vwr: tail, cyc: cyc + 3});
        end
        if (has_tail && drop) begin
            if (n >= 7) begin
                m_mac = pw[6][127:80]; m_dir = pw[6][79];
                m_tb = pw[6][63:32]; m_slot = pw[6][31:0];
                m_master = ~m_master; m_cnt = m_cnt + 16'd1;
            end else if (m_err != 16'hffff) begin
                m_err = m_err + 16'd1;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_cfg();
            drive_idle();
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (lu.out_lu_data_wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", lu.out_lu_data, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", lu.out_lu_data, e.data);
                    chk("out_valid", lu.out_lu_data_valid, e.valid);
                    chk("out_valid_wr", lu.out_lu_data_valid_wr, e.vwr);
                    chk("latency", cyc, e.cyc);
                end
            end else begin
                chk("idle_out_zero", {lu.out_lu_data, lu.out_lu_data_valid,
                                      lu.out_lu_data_valid_wr}, '0);
            end
        end
    end

    initial begin
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", dbg_state, 2'd0);
        check_cfg();
        #2 rst_n = 1'b1;

        // Pass-through of a plain IP frame
        make_pkt(0);
        pw[2][31:16] = 16'h0800;
        send_pkt(5, 1'b1, 3);

        // Valid update
        make_pkt(0);
        pw[6] = {48'h0a0b0c0d0e0f, 1'b1, 15'b0, 32'h1234, 32'd500};
        send_pkt(8, 1'b1, 2);
        chk("t2_slot", slot, 32'd500);
        chk("t2_tb", tb_para, 32'h1234);
        chk("t2_dir", dir, 1'b1);
        chk("t2_master", master, 1'b1);
        chk("t2_cnt", cnt, 16'd1);

        // Update addressed to another switch
        make_pkt(1);
        send_pkt(8, 1'b1, 2);

        // Truncated update
        make_pkt(0);
        send_pkt(5, 1'b1, 2);
        chk("t4_err", err_cnt, 16'd1);

        // Update aborted by a new head, then a normal packet
        make_pkt(0);
        send_pkt(4, 1'b0, 0);
        make_pkt(2);
        send_pkt(4, 1'b1, 5);

        // Reset while word 6 of a matching update is on the input
        make_pkt(0);
        send_pkt(7, 1'b0, 0);
        #2 rst_n = 1'b0;
        drive_idle();
        exp_q.delete();
        model_reset();
        #1;
        chk("t6_out_wr", lu.out_lu_data_wr, 1'b0);
        chk("t6_state", dbg_state, 2'd0);
        check_cfg();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_cfg();
        end

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            int kind;
            kind = $urandom_range(0, 5);
            make_pkt(kind >= 3 ? 0 : kind + 1);
            send_pkt($urandom_range(2, 18), $urandom_range(0, 7) != 0, $urandom_range(0, 2));
        end

        @(negedge clk);
        drive_idle();
        repeat (6) begin
            @(negedge clk);
            check_cfg();
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
